// File: rtl/video_timing_pkg.sv
// Shared types and default 1080p60 timing for the video timing generator and its benches.
package video_timing_pkg;

   localparam int unsigned COORD_W = 12;

   typedef enum logic [1:0] {
      PH_SYNC   = 2'd0,
      PH_BACK   = 2'd1,
      PH_ACTIVE = 2'd2,
      PH_FRONT  = 2'd3
   } phase_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } run_state_t;

   localparam int unsigned DEF_H_ACTIVE = 1920;
   localparam int unsigned DEF_H_FRONT  = 88;
   localparam int unsigned DEF_H_SYNC   = 44;
   localparam int unsigned DEF_H_BACK   = 148;
   localparam int unsigned DEF_V_ACTIVE = 1080;
   localparam int unsigned DEF_V_FRONT  = 4;
   localparam int unsigned DEF_V_SYNC   = 5;
   localparam int unsigned DEF_V_BACK   = 36;

endpackage

// File: rtl/video_timing_axis.sv
// One raster axis: position counter plus SYNC/BACK/ACTIVE/FRONT phase FSM.
module video_timing_axis
   import video_timing_pkg::*;
#(
   parameter int unsigned SYNC   = DEF_H_SYNC,
   parameter int unsigned BACK   = DEF_H_BACK,
   parameter int unsigned ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned FRONT  = DEF_H_FRONT
) (
   input  logic               pixel_clk,
   input  logic               reset,
   input  logic               step,
   input  logic               run,
   output logic [COORD_W-1:0] count,
   output phase_t             phase,
   output logic               wrap
);

   localparam int unsigned TOTAL = SYNC + BACK + ACTIVE + FRONT;
   localparam logic [COORD_W-1:0] END_SYNC   = COORD_W'(SYNC - 1);
   localparam logic [COORD_W-1:0] END_BACK   = COORD_W'(SYNC + BACK - 1);
   localparam logic [COORD_W-1:0] END_ACTIVE = COORD_W'(SYNC + BACK + ACTIVE - 1);
   localparam logic [COORD_W-1:0] LAST       = COORD_W'(TOTAL - 1);

   logic [COORD_W-1:0] count_d;
   phase_t             phase_d;

   assign wrap = run && (count == LAST);

   always_ff @(posedge pixel_clk or posedge reset) begin
      if (reset) begin
         count <= '0;
         phase <= PH_SYNC;
      end else begin
         count <= count_d;
         phase <= phase_d;
      end
   end

   always_comb begin
      count_d = count;
      phase_d = phase;
      if (!run) begin
         count_d = '0;
         phase_d = PH_SYNC;
      end else if (step) begin
         count_d = wrap ? '0 : count + 1'b1;
         // Phase advances on the last count of each region, so it always matches count_d.
         case (phase)
            PH_SYNC:   if (count == END_SYNC)   phase_d = PH_BACK;
            PH_BACK:   if (count == END_BACK)   phase_d = PH_ACTIVE;
            PH_ACTIVE: if (count == END_ACTIVE) phase_d = PH_FRONT;
            PH_FRONT:  if (count == LAST)       phase_d = PH_SYNC;
            default:   phase_d = PH_SYNC;
         endcase
      end
   end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing source with frame-granular start/stop and registered outputs.
// Optional frame_start pulse output when VIDEO_TIMING_GEN_FRAME_PULSE_EN is defined.
module video_timing_gen
   import video_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned H_FRONT  = DEF_H_FRONT,
   parameter int unsigned H_SYNC   = DEF_H_SYNC,
   parameter int unsigned H_BACK   = DEF_H_BACK,
   parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
   parameter int unsigned V_FRONT  = DEF_V_FRONT,
   parameter int unsigned V_SYNC   = DEF_V_SYNC,
   parameter int unsigned V_BACK   = DEF_V_BACK,
   parameter bit          SYNC_POL = 1'b0
) (
   input  logic               pixel_clk,
   input  logic               reset,
   input  logic               enable,
   output logic               busy,
   output logic               pixel_de,
   output logic               pixel_hs,
   output logic               pixel_vs,
   output logic [COORD_W-1:0] pixel_x,
   output logic [COORD_W-1:0] pixel_y,
   output logic [COORD_W-1:0] image_width,
   output logic [COORD_W-1:0] image_height
`ifdef VIDEO_TIMING_GEN_FRAME_PULSE_EN
   ,
   output logic               frame_start
`endif
);

   localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
   localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
   localparam logic [COORD_W-1:0] X_OFS = COORD_W'(H_SYNC + H_BACK);
   localparam logic [COORD_W-1:0] Y_OFS = COORD_W'(V_SYNC + V_BACK);

   if (H_TOTAL > 4096) begin : g_h_total_chk
      $error("video_timing_gen: H_TOTAL exceeds 12-bit counter range");
   end
   if (V_TOTAL > 4096) begin : g_v_total_chk
      $error("video_timing_gen: V_TOTAL exceeds 12-bit counter range");
   end

   run_state_t         state_q, state_d;
   logic               running;
   logic [COORD_W-1:0] h_cnt, v_cnt;
   phase_t             h_phase, v_phase;
   logic               h_wrap, v_wrap;

   assign running      = (state_q == ST_RUN);
   assign image_width  = COORD_W'(H_ACTIVE);
   assign image_height = COORD_W'(V_ACTIVE);

   video_timing_axis #(
      .SYNC   (H_SYNC),
      .BACK   (H_BACK),
      .ACTIVE (H_ACTIVE),
      .FRONT  (H_FRONT)
   ) u_h_axis (
      .pixel_clk (pixel_clk),
      .reset     (reset),
      .step      (1'b1),
      .run       (running),
      .count     (h_cnt),
      .phase     (h_phase),
      .wrap      (h_wrap)
   );

   video_timing_axis #(
      .SYNC   (V_SYNC),
      .BACK   (V_BACK),
      .ACTIVE (V_ACTIVE),
      .FRONT  (V_FRONT)
   ) u_v_axis (
      .pixel_clk (pixel_clk),
      .reset     (reset),
      .step      (h_wrap),
      .run       (running),
      .count     (v_cnt),
      .phase     (v_phase),
      .wrap      (v_wrap)
   );

   always_ff @(posedge pixel_clk or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Stop is only honoured at the frame wrap; the counters wrap to 0 on the same edge.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (enable)                      state_d = ST_RUN;
         ST_RUN:  if (h_wrap && v_wrap && !enable) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge pixel_clk or posedge reset) begin
      if (reset) begin
         busy     <= 1'b0;
         pixel_de <= 1'b0;
         pixel_hs <= ~SYNC_POL;
         pixel_vs <= ~SYNC_POL;
         pixel_x  <= '0;
         pixel_y  <= '0;
      end else if (running) begin
         busy     <= 1'b1;
         pixel_de <= (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
         pixel_hs <= (h_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
         pixel_vs <= (v_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
         pixel_x  <= (h_phase == PH_ACTIVE) ? h_cnt - X_OFS : '0;
         pixel_y  <= (v_phase == PH_ACTIVE) ? v_cnt - Y_OFS : '0;
      end else begin
         busy     <= 1'b0;
         pixel_de <= 1'b0;
         pixel_hs <= ~SYNC_POL;
         pixel_vs <= ~SYNC_POL;
         pixel_x  <= '0;
         pixel_y  <= '0;
      end
   end

`ifdef VIDEO_TIMING_GEN_FRAME_PULSE_EN
   always_ff @(posedge pixel_clk or posedge reset) begin
      if (reset) frame_start <= 1'b0;
      else       frame_start <= running && (h_cnt == '0) && (v_cnt == '0);
   end
`endif

endmodule
